nonce_dispatcher: RTL and testbench
===================================

Name: nonce_dispatcher

Overview:
- Sequences one nonce search across NUM_CORES SHA-256 hash cores.
- Takes the start pulse and the nonce range from the CSR block, then hands one nonce per cycle to the lowest-index idle core.
- Collects each core's done/hit result and drives the complete, found and foundNonce status back into the Avalon slave CSR bank.
- Sits between the Avalon slave and the hash core array.

Parameters:
NUM_CORES, 4, number of hash cores dispatched to (1..16)
NONCE_W, 32, nonce width in bits

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a search over [nonce_begin, nonce_end]
abort  input  1  one-cycle pulse; terminates the current search
nonce_begin  input  NONCE_W  first nonce, inclusive; sampled on accepted start
nonce_end  input  NONCE_W  last nonce, inclusive; sampled on accepted start
core_start  output  NUM_CORES  one-hot, one-cycle launch pulse to a core
core_nonce  output  NONCE_W  nonce for the core being launched; valid with core_start
core_done  input  NUM_CORES  per-core one-cycle completion pulse
core_hit  input  NUM_CORES  per-core hit flag; qualified by core_done
busy  output  1  search in progress (DISPATCH or DRAIN)
complete  output  1  search finished; to csr_registers[0][0]
found  output  1  a hit was recorded; to csr_registers[0][1]
found_nonce  output  NONCE_W  winning nonce; to the foundNonce CSR
hashes_done  output  32  completed-hash count (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs and internal registers zero; per-core active bits cleared.
- Registers:
  - next_nonce, NONCE_W+1 bits, so nonce_end=all-ones terminates without wrap.
  - end_reg, NONCE_W bits.
  - active[NUM_CORES].
  - per-core nonce_tag[NUM_CORES][NONCE_W].
  - stop_reason: hit / exhausted / abort.
- States:
  - IDLE: wait for start.
  - DISPATCH: launch nonces.
  - DRAIN: wait until active==0.
  - DONE: hold results.
- Accepting start (IDLE or DONE only):
  - next cycle: state DISPATCH; next_nonce={0,nonce_begin}; end_reg=nonce_end.
  - complete, found and found_nonce cleared; hashes_done cleared.
  - start while busy is ignored.
- nonce_begin > nonce_end: start goes directly to DONE one cycle later; complete=1, found=0; no core_start is issued.
- DISPATCH, each cycle:
  - if any core has active=0 and next_nonce<=end_reg, pulse core_start for the lowest such index.
  - drive core_nonce=next_nonce[NONCE_W-1:0], set that core's active bit and nonce_tag, increment next_nonce.
  - at most one launch per cycle.
  - first launch occurs in the cycle after start is accepted.
- Launch eligibility uses the registered active bits from the start of the cycle; a core finishing this cycle is eligible next cycle.
- core_done[i]:
  - clears active[i]; a pulse on an inactive core is ignored.
  - if core_hit[i] is also high, record found_nonce=nonce_tag[i], set the found flag, and stop dispatching.
  - a launch in the same cycle as the hit is still allowed to complete.
- Multiple hits in the same cycle: the lowest core index wins.
- A hit in DRAIN after a prior hit does not overwrite found_nonce; the first hit wins.
- Exhaustion: next_nonce>end_reg in DISPATCH moves the state to DRAIN.
- DISPATCH with a hit recorded moves the state to DRAIN.
- DRAIN → DONE on the cycle active==0:
  - complete=1.
  - found=1 if a hit was recorded.
  - outputs hold until the next accepted start or reset.
- Abort in DISPATCH or DRAIN:
  - stop dispatching, drain, then go to IDLE with complete=0 and found=0.
  - results of cores finishing during the drain are discarded.
  - abort in IDLE or DONE has no effect.
- Simultaneous start and abort in DONE: start wins.
- busy=1 exactly in DISPATCH and DRAIN.
- reset asserted mid-search: all state clears next edge; core_start is low from that edge on.

Optional Feature:
- Macro NONCE_DISPATCHER_STATS_EN.
- Defined:
  - hashes_done counts every qualified core_done pulse while busy, multiple per cycle summed.
  - saturates at 32'hFFFFFFFF; cleared on accepted start.
- Not defined: hashes_done tied to 0; no counter logic inferred.

Test Plan:
- NUM_CORES=4, cores done 3 cycles after launch, range 0x10..0x17, no hits → launches 0x10,0x11,0x12,0x13 on cores 0..3 in consecutive cycles; all 8 nonces issued exactly once; complete=1, found=0; hashes_done=8 with STATS_EN.
- Same setup, core reporting hit for nonce 0x12 → no launch after the hit cycle except the one already issued that cycle; DONE with found=1, found_nonce=0x12.
- Cores 1 and 3 hit in the same cycle on nonces 0x21 and 0x23 → found_nonce=0x21; a later hit on 0x24 is ignored.
- Range 0xFFFFFFFE..0xFFFFFFFF → exactly two launches, no wrap to 0; complete=1. Range 5..4 → DONE in 1 cycle, no core_start, complete=1, found=0.
- abort two cycles into a 0..0xFF search with one core hitting during drain → drains to IDLE; complete=0, found=0, busy falls once active==0.
- start pulsed again while busy → ignored (range unchanged). reset asserted mid-DISPATCH → all outputs 0 next cycle; a fresh start then runs normally.

Source files
------------

// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher
// Sequences one nonce search across NUM_CORES hash cores. An accepted start
// latches [nonce_begin, nonce_end]; each DISPATCH cycle the next nonce goes to
// the lowest-index idle core. Core done/hit results are collected and the
// first hit (lowest core index on ties) is reported as found_nonce.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   start, abort         one-cycle control pulses from the CSR block
//   nonce_begin/end      inclusive search range, sampled on accepted start
//   core_start/nonce     one-hot launch pulse and its nonce
//   core_done/hit        per-core completion pulse and qualified hit flag
//   busy                 high in DISPATCH and DRAIN
//   complete, found      search status, held until next start or reset
//   found_nonce          winning nonce
//   hashes_done          completed-hash count
//
// Optional feature: define NONCE_DISPATCHER_STATS_EN to build the saturating
// hashes_done counter; otherwise hashes_done is tied to zero.
module nonce_dispatcher #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned NONCE_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NONCE_W-1:0]   nonce_begin,
    input  logic [NONCE_W-1:0]   nonce_end,
    output logic [NUM_CORES-1:0] core_start,
    output logic [NONCE_W-1:0]   core_nonce,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [NUM_CORES-1:0] core_hit,
    output logic                 busy,
    output logic                 complete,
    output logic                 found,
    output logic [NONCE_W-1:0]   found_nonce,
    output logic [31:0]          hashes_done
);

    typedef enum logic [1:0] {StIdle, StDispatch, StDrain, StDone} state_e;

    state_e               r_state;
    state_e               w_state_d;
    // One extra bit so a range ending at all-ones terminates instead of wrapping.
    logic [NONCE_W:0]     r_next_nonce;
    logic [NONCE_W-1:0]   r_end;
    logic [NUM_CORES-1:0] r_active;
    logic [NONCE_W-1:0]   r_tag [NUM_CORES];
    logic                 r_hit;
    logic                 r_abort;
    logic                 r_complete;
    logic                 r_found;
    logic [NONCE_W-1:0]   r_found_nonce;

    logic                 w_busy;
    logic                 w_accept_start;
    logic                 w_empty_range;
    logic                 w_have_nonce;
    logic                 w_can_launch;
    logic                 w_hit_take;
    logic                 w_drained;
    logic                 w_abort_fin;
    logic [NUM_CORES-1:0] w_idle;
    logic [NUM_CORES-1:0] w_launch;
    logic [NUM_CORES-1:0] w_done;
    logic [NUM_CORES-1:0] w_hits;
    logic [NONCE_W-1:0]   w_hit_nonce;

    assign w_busy         = (r_state == StDispatch) || (r_state == StDrain);
    assign w_accept_start = start && ((r_state == StIdle) || (r_state == StDone));
    assign w_empty_range  = nonce_begin > nonce_end;
    assign w_have_nonce   = r_next_nonce <= {1'b0, r_end};
    assign w_can_launch   = (r_state == StDispatch) && !abort && w_have_nonce;
    assign w_idle         = ~r_active;
    // x & -x isolates the lowest idle core.
    assign w_launch       = w_can_launch ? (w_idle & (~w_idle + NUM_CORES'(1))) : '0;

    // Done pulses on cores that were never launched are ignored.
    assign w_done         = core_done & r_active;
    assign w_hits         = w_done & core_hit;
    assign w_hit_take     = w_busy && !r_abort && !abort && !r_hit && (|w_hits);
    assign w_drained      = (r_state == StDrain) && (r_active == '0);
    assign w_abort_fin    = r_abort || abort;

    // Lowest hitting core wins: scan downward so the last match is the lowest.
    always_comb begin
        w_hit_nonce = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_hits[i]) w_hit_nonce = r_tag[i];
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle, StDone: begin
                if (w_accept_start) w_state_d = w_empty_range ? StDone : StDispatch;
            end
            StDispatch: begin
                if (abort || w_hit_take || !w_have_nonce) w_state_d = StDrain;
            end
            StDrain: begin
                if (r_active == '0) w_state_d = w_abort_fin ? StIdle : StDone;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_next_nonce  <= '0;
            r_end         <= '0;
            r_active      <= '0;
            r_hit         <= 1'b0;
            r_abort       <= 1'b0;
            r_complete    <= 1'b0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            for (int i = 0; i < NUM_CORES; i++) r_tag[i] <= '0;
        end else begin
            r_active <= (r_active & ~core_done) | w_launch;
            if (|w_launch) r_next_nonce <= r_next_nonce + 1'b1;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_launch[i]) r_tag[i] <= r_next_nonce[NONCE_W-1:0];
            end
            if (w_busy && abort) r_abort <= 1'b1;
            if (w_hit_take) begin
                r_hit         <= 1'b1;
                r_found_nonce <= w_hit_nonce;
            end
            if (w_drained) begin
                if (w_abort_fin) begin
                    // Aborted search leaves no result behind.
                    r_complete    <= 1'b0;
                    r_found       <= 1'b0;
                    r_found_nonce <= '0;
                    r_hit         <= 1'b0;
                    r_abort       <= 1'b0;
                end else begin
                    r_complete <= 1'b1;
                    r_found    <= r_hit;
                end
            end
            if (w_accept_start) begin
                r_next_nonce  <= {1'b0, nonce_begin};
                r_end         <= nonce_end;
                r_hit         <= 1'b0;
                r_abort       <= 1'b0;
                r_found       <= 1'b0;
                r_found_nonce <= '0;
                r_complete    <= w_empty_range;
            end
        end
    end

    assign core_start  = w_launch;
    assign core_nonce  = (|w_launch) ? r_next_nonce[NONCE_W-1:0] : '0;
    assign busy        = w_busy;
    assign complete    = r_complete;
    assign found       = r_found;
    assign found_nonce = r_found_nonce;

`ifdef NONCE_DISPATCHER_STATS_EN
    logic [31:0] r_hashes;
    logic [4:0]  w_done_cnt;
    logic [32:0] w_hash_sum;

    always_comb begin
        w_done_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) w_done_cnt = w_done_cnt + 5'(w_done[i]);
    end

    assign w_hash_sum = {1'b0, r_hashes} + 33'(w_done_cnt);

    always_ff @(posedge clk) begin
        if (reset)               r_hashes <= '0;
        else if (w_accept_start) r_hashes <= '0;
        else if (w_busy)         r_hashes <= w_hash_sum[32] ? 32'hFFFF_FFFF : w_hash_sum[31:0];
    end

    assign hashes_done = r_hashes;
`else
    assign hashes_done = '0;
`endif

endmodule

// File: tb/tb_nonce_dispatcher.sv
// tb_nonce_dispatcher
// Directed bench for nonce_dispatcher. Emulated hash cores answer a fixed
// per-core latency after launch, hitting on a chosen set of nonces. A
// reference model built from core ownership and the nonce range predicts every
// output each cycle; literal expectations per scenario pin the model.
module tb_nonce_dispatcher;
    localparam int NC = 4;
    localparam int NW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [NW-1:0] nonce_begin;
    logic [NW-1:0] nonce_end;
    logic [NC-1:0] core_start;
    logic [NW-1:0] core_nonce;
    logic [NC-1:0] core_done;
    logic [NC-1:0] core_hit;
    logic          busy;
    logic          complete;
    logic          found;
    logic [NW-1:0] found_nonce;
    logic [31:0]   hashes_done;

    nonce_dispatcher #(.NUM_CORES(NC), .NONCE_W(NW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .nonce_begin (nonce_begin),
        .nonce_end   (nonce_end),
        .core_start  (core_start),
        .core_nonce  (core_nonce),
        .core_done   (core_done),
        .core_hit    (core_hit),
        .busy        (busy),
        .complete    (complete),
        .found       (found),
        .found_nonce (found_nonce),
        .hashes_done (hashes_done)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    bit     chk_en  = 0;
    int     base    = 0;

    // Core emulation
    int     lat [NC];
    longint hitq [$];
    int     done_time [NC];
    bit     done_hit [NC];
    longint log_nonce [$];
    int     log_core [$];

    // Reference model: phase 0 idle, 1 dispatch, 2 drain, 3 done
    int     m_st;
    longint m_next, m_end, m_fn, m_hashes;
    longint m_owner [NC];
    bit     m_hit, m_ab, m_complete, m_found;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit is_hit(input longint n);
        foreach (hitq[k]) if (hitq[k] == n) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_st = 0; m_next = 0; m_end = 0; m_fn = 0; m_hashes = 0;
        m_hit = 0; m_ab = 0; m_complete = 0; m_found = 0;
        for (int i = 0; i < NC; i++) m_owner[i] = -1;
    endtask

    // One clock cycle: check outputs and advance the model at negedge, then
    // cross the posedge and drive the emulated core responses.
    task automatic step();
        logic [NC-1:0] exp_start;
        longint        exp_nonce;
        int            li, hi, nd;
        bit            all_free, busy_now, hit_now, exhausted;
        @(negedge clk);
        exp_start = '0;
        exp_nonce = 0;
        li = -1;
        if (m_st == 1 && !abort && m_next <= m_end) begin
            for (int i = NC - 1; i >= 0; i--) if (m_owner[i] < 0) li = i;
        end
        if (li >= 0) begin
            exp_start[li] = 1'b1;
            exp_nonce = m_next;
        end
        if (chk_en) begin
            check("core_start", core_start, exp_start);
            if (li >= 0) check("core_nonce", core_nonce, exp_nonce);
            check("busy", busy, (m_st == 1 || m_st == 2));
            check("complete", complete, m_complete);
            check("found", found, m_found);
            check("found_nonce", found_nonce, m_fn);
            check("hashes_done", hashes_done, m_hashes);
        end
        if (reset) begin
            for (int i = 0; i < NC; i++) done_time[i] = -100;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    done_time[i] = cyc + lat[i];
                    done_hit[i]  = is_hit(longint'(core_nonce));
                    log_nonce.push_back(longint'(core_nonce));
                    log_core.push_back(i);
                end
            end
        end
        if (reset) begin
            model_reset();
        end else begin
            all_free = 1;
            for (int i = 0; i < NC; i++) if (m_owner[i] >= 0) all_free = 0;
            hi = -1;
            nd = 0;
            for (int i = NC - 1; i >= 0; i--) begin
                if (core_done[i] && m_owner[i] >= 0) begin
                    nd++;
                    if (core_hit[i]) hi = i;
                end
            end
            busy_now = (m_st == 1 || m_st == 2);
            hit_now  = busy_now && !m_ab && !abort && !m_hit && hi >= 0;
`ifdef NONCE_DISPATCHER_STATS_EN
            if (busy_now) begin
                m_hashes = m_hashes + nd;
                if (m_hashes > 64'hFFFF_FFFF) m_hashes = 64'hFFFF_FFFF;
            end
`endif
            if (hit_now) begin
                m_hit = 1;
                m_fn  = m_owner[hi];
            end
            for (int i = 0; i < NC; i++) if (core_done[i] && m_owner[i] >= 0) m_owner[i] = -1;
            exhausted = m_next > m_end;
            if (li >= 0) begin
                m_owner[li] = m_next;
                m_next++;
            end
            case (m_st)
                0, 3: if (start) begin
                    m_next = longint'(nonce_begin);
                    m_end  = longint'(nonce_end);
                    m_hit = 0; m_ab = 0; m_fn = 0; m_found = 0; m_hashes = 0;
                    if (m_next > m_end) begin m_st = 3; m_complete = 1; end
                    else begin m_st = 1; m_complete = 0; end
                end
                1: begin
                    if (abort) begin m_ab = 1; m_st = 2; end
                    else if (hit_now || exhausted) m_st = 2;
                end
                2: begin
                    if (abort) m_ab = 1;
                    if (all_free) begin
                        if (m_ab) begin
                            m_st = 0; m_complete = 0; m_found = 0; m_fn = 0;
                            m_hit = 0; m_ab = 0;
                        end else begin
                            m_st = 3; m_complete = 1; m_found = m_hit;
                        end
                    end
                end
                default: m_st = 0;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NC; i++) begin
            core_done[i] = (done_time[i] == cyc);
            core_hit[i]  = core_done[i] && done_hit[i];
        end
    endtask

    task automatic launch_search(input logic [NW-1:0] b, input logic [NW-1:0] e);
        nonce_begin = b;
        nonce_end   = e;
        base        = log_nonce.size();
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic run_until_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 300) begin
            step();
            k++;
        end
        check({name, " drain timeout"}, (k >= 300), 0);
    endtask

    task automatic set_lat(input int a, input int b, input int c, input int d);
        lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
    endtask

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        nonce_begin = '0; nonce_end = '0; core_done = '0; core_hit = '0;
        for (int i = 0; i < NC; i++) begin done_time[i] = -100; done_hit[i] = 0; end
        set_lat(3, 3, 3, 3);
        model_reset();

        repeat (3) step();
        check("reset busy", busy, 0);
        check("reset complete", complete, 0);
        check("reset core_start", core_start, 0);
        check("reset found_nonce", found_nonce, 0);
        check("reset hashes", hashes_done, 0);
        reset  = 1'b0;
        chk_en = 1;
        step();

        // Full range, no hits; spurious done+hit on idle core 3; start while busy.
        hitq.delete();
        launch_search(32'h10, 32'h17);
        core_done[3] = 1'b1;
        core_hit[3]  = 1'b1;
        step();
        step();
        nonce_begin = 32'h100; nonce_end = 32'h200; start = 1'b1;
        step();
        start = 1'b0;
        run_until_idle("t1");
        check("t1 launches", log_nonce.size() - base, 8);
        if (log_nonce.size() - base >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check("t1 order nonce", log_nonce[base + k], 32'h10 + k);
                check("t1 order core", log_core[base + k], k);
            end
        end
        for (int n = 16; n < 24; n++) begin
            cnt = 0;
            for (int k = base; k < log_nonce.size(); k++) if (log_nonce[k] == n) cnt++;
            check("t1 issued once", cnt, 1);
        end
        check("t1 complete", complete, 1);
        check("t1 found", found, 0);
`ifdef NONCE_DISPATCHER_STATS_EN
        check("t1 hashes", hashes_done, 8);
`else
        check("t1 hashes", hashes_done, 0);
`endif

        // Hit on 0x12: the launch issued in the hit cycle (0x15) is the last.
        hitq.delete();
        hitq.push_back(32'h12);
        launch_search(32'h10, 32'h17);
        run_until_idle("t2");
        check("t2 launches", log_nonce.size() - base, 6);
        if (log_nonce.size() - base >= 6) check("t2 last nonce", log_nonce[base + 5], 32'h15);
        check("t2 complete", complete, 1);
        check("t2 found", found, 1);
        check("t2 found_nonce", found_nonce, 32'h12);
`ifdef NONCE_DISPATCHER_STATS_EN
        check("t2 hashes", hashes_done, 6);
`endif

        // Cores 1 and 3 hit together; later hit on 0x24 is ignored.
        hitq.delete();
        hitq.push_back(32'h21); hitq.push_back(32'h23); hitq.push_back(32'h24);
        set_lat(3, 4, 3, 2);
        launch_search(32'h20, 32'h2F);
        run_until_idle("t3");
        check("t3 launches", log_nonce.size() - base, 5);
        check("t3 found", found, 1);
        check("t3 found_nonce", found_nonce, 32'h21);
        check("t3 complete", complete, 1);

        // Top of range: two launches, no wrap.
        hitq.delete();
        set_lat(3, 3, 3, 3);
        launch_search(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_until_idle("t4");
        check("t4 launches", log_nonce.size() - base, 2);
        if (log_nonce.size() - base >= 2) check("t4 second", log_nonce[base + 1], 32'hFFFF_FFFF);
        check("t4 complete", complete, 1);
        check("t4 found", found, 0);

        // Empty range: DONE one cycle later, nothing launched.
        launch_search(32'h5, 32'h4);
        check("t5 complete", complete, 1);
        check("t5 found", found, 0);
        check("t5 busy", busy, 0);
        repeat (3) step();
        check("t5 launches", log_nonce.size() - base, 0);

        // Start with abort in DONE (start wins), then abort; hit during drain discarded.
        hitq.delete();
        hitq.push_back(1);
        nonce_begin = 32'h0; nonce_end = 32'hFF;
        base  = log_nonce.size();
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("t6 start wins", busy, 1);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        run_until_idle("t6");
        check("t6 launches", log_nonce.size() - base, 2);
        check("t6 complete", complete, 0);
        check("t6 found", found, 0);
        check("t6 found_nonce", found_nonce, 0);

        // Reset mid-dispatch, then a fresh search.
        hitq.delete();
        launch_search(32'h40, 32'h7F);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t7 core_start", core_start, 0);
        check("t7 busy", busy, 0);
        check("t7 complete", complete, 0);
        check("t7 found_nonce", found_nonce, 0);
        check("t7 hashes", hashes_done, 0);
        step();
        launch_search(32'h10, 32'h17);
        run_until_idle("t7 rerun");
        check("t7 rerun launches", log_nonce.size() - base, 8);
        check("t7 rerun complete", complete, 1);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
